// File: rtl/mem_pkg.sv
// Shared constants and helpers for the memory-group blocks.
package mem_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // Address width for a given entry count; never below 1 bit.
    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// WIDTHxDEPTH register array: one write port, one registered read port.
module fifo_mem
    import mem_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Array is deliberately left without reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer, occupancy, status flags and error pulses.
module sync_fifo
    import mem_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = ptr_w(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             ovf,
    output logic             udf
);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_acc, rd_acc;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    // A read in the same cycle frees a slot, so a full FIFO still takes the write.
    assign wr_acc = wr_en & (~full | rd_en);
    assign rd_acc = rd_en & ~empty;

    fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .re    (rd_acc & ~rst),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr_acc && !rd_acc)
                count <= count + CW'(1);
            else if (rd_acc && !wr_acc)
                count <= count - CW'(1);
            ovf <= wr_en & full & ~rd_en;
            udf <= rd_en & empty;
        end
    end
endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: reference queue model checked every cycle.
module tb_sync_fifo;
    localparam int W  = 8;
    localparam int D  = 8;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          rd_en = 1'b0;
    logic [W-1:0]  rd_data;
    logic          full, empty, ovf, udf;
    logic [CW-1:0] count;

    int vecs = 0;
    int miss = 0;

    logic [W-1:0] mq [$];     // reference contents
    logic [W-1:0] exp_q [$];  // expected read results
    logic [W-1:0] m_rd = '0;
    logic         m_ovf = 1'b0, m_udf = 1'b0;

    sync_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .full(full), .empty(empty),
        .count(count), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input logic w, input logic [W-1:0] d, input logic r, input logic rs);
        logic racc, wacc, mfull, mempty;
        wr_en = w; wr_data = d; rd_en = r; rst = rs;
        mfull  = (mq.size() == D);
        mempty = (mq.size() == 0);
        racc = 1'b0;
        if (rs) begin
            mq.delete(); exp_q.delete();
            m_rd = '0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            wacc  = w && (!mfull || r);
            racc  = r && !mempty;
            m_ovf = w && mfull && !r;
            m_udf = r && mempty;
            if (racc) exp_q.push_back(mq.pop_front());
            if (wacc) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        if (racc) begin
            m_rd = exp_q.pop_front();
            chk("rd_data", rd_data, m_rd);
        end else begin
            chk("rd_hold", rd_data, m_rd);
        end
        chk("count", count, mq.size());
        chk("full",  full,  mq.size() == D);
        chk("empty", empty, mq.size() == 0);
        chk("ovf",   ovf,   m_ovf);
        chk("udf",   udf,   m_udf);
        wr_en = 1'b0; rd_en = 1'b0; rst = 1'b0;
    endtask

    initial begin
        step(0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0);

        step(1, 8'h11, 0, 0); step(1, 8'h22, 0, 0); step(1, 8'h33, 0, 0);
        step(0, 0, 1, 0); chk("seq_rd0", rd_data, 8'h11);
        step(0, 0, 1, 0); chk("seq_rd1", rd_data, 8'h22);
        step(0, 0, 1, 0); chk("seq_rd2", rd_data, 8'h33);

        for (int i = 0; i < D; i++) step(1, W'(8'hA0 + i), 0, 0);
        chk("fill_full", full, 1'b1);
        step(1, 8'hFF, 0, 0);
        chk("ovf_pulse", ovf, 1'b1);
        step(0, 0, 0, 0);
        for (int i = 0; i < D; i++) step(0, 0, 1, 0);
        chk("drain_last", rd_data, 8'hA7);

        for (int i = 0; i < D; i++) step(1, W'(8'hA0 + i), 0, 0);
        step(1, 8'hB0, 1, 0);
        chk("full_rw_rd", rd_data, 8'hA0);
        chk("full_rw_cnt", count, D);
        for (int i = 0; i < D; i++) step(0, 0, 1, 0);
        chk("wrap_last", rd_data, 8'hB0);

        step(0, 0, 1, 0);
        chk("udf_pulse", udf, 1'b1);
        step(1, 8'h5C, 1, 0);
        chk("udf_rw_cnt", count, 1);
        step(0, 0, 1, 0);
        chk("udf_rw_rd", rd_data, 8'h5C);

        for (int i = 0; i < 4; i++) step(1, W'(8'h40 + i), 0, 0);
        step(1, 8'hEE, 1, 1);
        chk("rst_cnt", count, 0);
        chk("rst_rd", rd_data, 0);
        step(1, 8'h77, 0, 0);
        step(0, 0, 1, 0);
        chk("post_rst_rd", rd_data, 8'h77);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 55, W'($urandom),
                 $urandom_range(0, 99) < 45, $urandom_range(0, 63) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Synchronous first-in/first-out buffer for the memory group. It stores a parameterised number of words in a register array. It sits directly downstream of the single-bit storage elements, packaging word storage behind a write/read handshake so that producer logic can hand data to a consumer running on the same clock. It provides full and empty status, an occupancy count, and one-cycle overflow and underflow error pulses.

## Interface
Parameters:
- `WIDTH`, 8: data word width in bits (≥1).
- `DEPTH`, 8: number of storage entries; power of two, ≥2.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset; sampled on the rising edge of `clk`.
- `wr_en` input 1: write request for this cycle.
- `wr_data` input WIDTH: word to write; sampled when the write is accepted.
- `rd_en` input 1: read request for this cycle.
- `rd_data` output WIDTH: word read; registered.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `count` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `ovf` output 1: one-cycle pulse, write rejected because full.
- `udf` output 1: one-cycle pulse, read rejected because empty.

## Operation
- Pointers: `wr_ptr`, `rd_ptr`, each $clog2(DEPTH) bits. Each wraps naturally from DEPTH-1 to 0.
- Acceptance, evaluated from state before the edge:
  - Write accepted = `wr_en` & (!full | rd_en).
  - Read accepted = `rd_en` & !empty.
- Accepted write: mem[wr_ptr] <= wr_data; wr_ptr += 1.
- Accepted read: rd_data <= mem[rd_ptr]; rd_ptr += 1.
- Not-accepted read: rd_data holds its previous value.
- Count update: +1 for write only, -1 for read only, unchanged for both or neither.
- Simultaneous read and write when full: both accepted, count stays DEPTH, no `ovf`. The read returns the oldest word, not the incoming one.
- Simultaneous read and write when empty: the read is rejected and `udf` pulses. The write is accepted and count becomes 1. No write-through: rd_data is unchanged.
- `ovf` = `wr_en` & full & !`rd_en`, registered for one cycle.
- `udf` = `rd_en` & empty, registered for one cycle.
- `full` and `empty` are derived from registered `count`. They are never both 1.
- Reset values: wr_ptr 0, rd_ptr 0, count 0, empty 1, full 0, rd_data 0, ovf 0, udf 0. Storage contents are not reset and are undefined.
- Reset mid-operation: all of the above values apply on the next edge. Requests in the reset cycle are ignored, with no ovf/udf pulse. Previously stored words become unreachable.

## Timing
- Write-to-read visibility: a word written at edge N makes `empty` fall after edge N. It can be read at edge N+1, and appears on rd_data after edge N+1.
- Read latency: 1 cycle. rd_data is valid in the cycle after the cycle where rd_en was accepted.
- Status (`full`, `empty`, `count`) updates in the cycle after the causing edge. There is no combinational path from `wr_en`/`rd_en` to any output.
- `ovf`/`udf` assert in the cycle after the offending request and last exactly one cycle per offending cycle.
- Throughput: one write and one read per cycle, sustained.

## Structure
- Shared package `mem_pkg`:
  - pointer-width helper constant/function (`$clog2`-based);
  - default WIDTH/DEPTH constants reused by other memory blocks.
- Sub-module `fifo_mem`: a WIDTH×DEPTH register array with one write port and one registered read port, no reset on the array. It is instantiated once.
- Pointer, count, flag and error logic live in `sync_fifo` itself.

## Test plan
- Reset, then idle 3 cycles: empty=1, full=0, count=0, rd_data=0, ovf=udf=0.
- Write 0x11,0x22,0x33 on consecutive cycles, then read 3 times: rd_data = 0x11, 0x22, 0x33 one cycle after each read; empty=1 after the last read; count sequence 1,2,3,2,1,0.
- Fill with DEPTH=8 words 0xA0..0xA7: full=1, count=8. Write 0xFF alone: ovf pulses one cycle, count stays 8, and draining returns 0xA0..0xA7 (no 0xFF).
- When full, assert wr_en=1 (0xB0) and rd_en=1 together: rd_data=0xA0, count stays 8, ovf=0. After draining, the last word read is 0xB0, confirming pointer wrap.
- When empty, assert rd_en=1 alone: udf pulses one cycle, rd_data unchanged. With rd_en and wr_en (0x5C) together: udf pulses, count=1, and the next read returns 0x5C.
- Load 4 words, assert rst for one cycle with wr_en=rd_en=1: next cycle count=0, empty=1, rd_data=0, no ovf/udf. A subsequent write/read of 0x77 returns 0x77.
